// File: rtl/dbg_arb_pkg.sv
// Shared types and constants for the register-file debug read arbiter.
package dbg_arb_pkg;

  localparam int DBG_ADDR_W = 5;
  localparam int DBG_DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } arb_state_e;

  localparam logic GNT_VGA = 1'b0;
  localparam logic GNT_MON = 1'b1;

endpackage

// File: rtl/dbg_arb_age_counter.sv
// Saturating age counter with synchronous clear; tracks how long the monitor
// requester has been losing arbitration.
module dbg_arb_age_counter #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam logic [W-1:0] MAX_CNT = W'(MAX);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != MAX_CNT)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign at_max_o = (count_q == MAX_CNT);

endmodule

// File: rtl/dbg_rf_read_arbiter.sv
// Two-requester arbiter for the register file debug read port (VGA screen and
// debug monitor). Optional starvation guard: define DBG_ARB_STARVE_GUARD_EN.
module dbg_rf_read_arbiter
  import dbg_arb_pkg::*;
#(
  parameter int ADDR_W   = DBG_ADDR_W,
  parameter int DATA_W   = DBG_DATA_W,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic              grant_q, grant_d;
  logic              rsp0_valid_q, rsp1_valid_q;
  logic [DATA_W-1:0] rsp0_data_q, rsp1_data_q;
  logic              win_mon;
  logic              force_mon;
  logic              rsp0_fire, rsp1_fire;

`ifdef DBG_ARB_STARVE_GUARD_EN
  localparam int AGE_W = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;

  logic age_inc, age_clr;

  // Age only advances on IDLE cycles where the monitor asked and lost.
  assign age_inc = (state_q == IDLE) && req1_valid && !win_mon;
  assign age_clr = !req1_valid || req1_ready;

  dbg_arb_age_counter #(
    .W  (AGE_W),
    .MAX(MAX_WAIT)
  ) u_age (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (age_inc),
    .clr_i   (age_clr),
    .at_max_o(force_mon)
  );
`else
  wire unused_max_wait = (MAX_WAIT < 0);
  assign force_mon = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    rf_addr_d  = rf_addr_q;
    grant_d    = grant_q;
    win_mon    = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          win_mon    = req1_valid && (!req0_valid || force_mon);
          // Ready is masked during reset so a requester never sees a phantom accept.
          req0_ready = !win_mon && rst_n;
          req1_ready = win_mon && rst_n;
          rf_addr_d  = win_mon ? req1_addr : req0_addr;
          grant_d    = win_mon ? GNT_MON : GNT_VGA;
          state_d    = READ;
        end
      end
      READ: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rsp0_fire = (state_q == READ) && (grant_q == GNT_VGA);
  assign rsp1_fire = (state_q == READ) && (grant_q == GNT_MON);

  // NOTE: response data registers are reset too: their value is visible on the
  // ports right after reset, so it must be defined rather than left as X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rf_addr_q    <= '0;
      grant_q      <= GNT_VGA;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      rf_addr_q    <= rf_addr_d;
      grant_q      <= grant_d;
      rsp0_valid_q <= rsp0_fire;
      rsp1_valid_q <= rsp1_fire;
      if (rsp0_fire) rsp0_data_q <= rf_data;
      if (rsp1_fire) rsp1_data_q <= rf_data;
    end
  end

  assign rf_addr    = rf_addr_q;
  assign busy       = (state_q == READ);
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;

endmodule

// File: doc/dbg_rf_read_arbiter.md
Name: dbg_rf_read_arbiter

Overview:
- Shares the single debug read port of the CPU register file between two requesters.
- Requester 0 is the VGA debug screen, which fetches register values for each text row. Requester 1 is a slower serial/JTAG-style debug monitor.
- Sequences one register read at a time: registers the address, samples the register file, and returns the data to the winning requester with a fixed latency.
- Sits between the register file debug port and the display/monitor clients, in the VGA clock domain.

Parameters:
ADDR_W, 5, register address width
DATA_W, 32, register data width
MAX_WAIT, 15, cycles requester 1 may lose arbitration consecutively before it is force-granted (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 (VGA) read request
req0_addr  in  ADDR_W  requester 0 register address
req0_ready  out  1  requester 0 request accepted this cycle
rsp0_valid  out  1  requester 0 response data valid (1-cycle pulse)
rsp0_data  out  DATA_W  requester 0 response data
req1_valid  in  1  requester 1 (monitor) read request
req1_addr  in  ADDR_W  requester 1 register address
req1_ready  out  1  requester 1 request accepted this cycle
rsp1_valid  out  1  requester 1 response valid (1-cycle pulse)
rsp1_data  out  DATA_W  requester 1 response data
rf_addr  out  ADDR_W  address driven to register file debug port
rf_data  in  DATA_W  combinational read data from register file
busy  out  1  high while in READ

Behaviour:
- Reset (async, rst_n=0): state=IDLE; rf_addr=0; rsp0_valid=rsp1_valid=0; rsp0_data=rsp1_data=0; grant_id=0; age counter=0; busy=0. Any in-flight read is dropped and no response is produced.
- State machine has two states:
  - IDLE: if any reqN_valid is high, pick a winner and assert its reqN_ready combinationally in this cycle. On the clock edge: rf_addr<=winner addr, grant_id<=winner, state<=READ. If no request, stay in IDLE.
  - READ: busy=1, rf_addr is held stable, no ready is asserted. On the clock edge: rspG_data<=rf_data, rspG_valid<=1 for one cycle, state<=IDLE.
- Latency: request accepted in cycle N -> rsp valid in cycle N+2. Max throughput is one read per 2 cycles.
- A new acceptance may occur in the same cycle that the previous rsp_valid is high (back-to-back).
- rspN_data holds its last value until the next response to that requester. The other requester's data is never modified.
- Handshake: a requester holds valid and addr stable until ready. Dropping valid before ready withdraws the request, which is legal. ready is never asserted in READ or during reset.
- Arbitration (default): fixed priority, requester 0 wins when both are valid.
- Simultaneous valid in IDLE: exactly one ready is asserted, never both.
- Address width: addr is passed through unchanged. The register file is responsible for treating address 0 as reading zero.
- Reset asserted in READ: return to IDLE at once; no rsp pulse on release.

Optional Feature:
- Macro: DBG_ARB_STARVE_GUARD_EN.
- Defined:
  - A 4-bit-min age counter (width clog2(MAX_WAIT+1)) increments each IDLE cycle in which req1_valid=1 and requester 0 wins.
  - The counter resets to 0 when requester 1 is granted or req1_valid=0.
  - When age==MAX_WAIT, requester 1 wins the next IDLE arbitration even if req0_valid=1.
- Undefined: strict priority, no counter is synthesized, and requester 1 may starve indefinitely.

Decomposition:
- Package dbg_arb_pkg holds:
  - the state enum (IDLE=1'b0, READ=1'b1);
  - grant id constants GNT_VGA=0, GNT_MON=1;
  - default widths DBG_ADDR_W=5, DBG_DATA_W=32.
- Sub-module dbg_arb_age_counter (saturating counter with clear, asynchronous active-low reset), instantiated only under DBG_ARB_STARVE_GUARD_EN.
- The rest is a single flat module.

Test Plan:
- Reset release, no requests -> rf_addr=0, all ready/valid=0, busy=0 for 10 cycles.
- req0 only, addr=5, rf_data models reg5=32'hDEADBEEF:
  - req0_ready in cycle N, rf_addr=5 in N+1;
  - rsp0_valid pulse in N+2 with rsp0_data=32'hDEADBEEF;
  - rsp1_valid stays 0.
- Both valid, addr0=3 and addr1=7:
  - req0_ready first, then req1_ready two cycles later;
  - rsp0 returns reg3, then rsp1 returns reg7;
  - rsp valid and the next acceptance coincide.
- req0 held valid continuously, req1 valid:
  - guard off: req1_ready never asserts over 100 cycles;
  - guard on, MAX_WAIT=15: req1_ready asserts after exactly 15 lost arbitrations.
- rst_n asserted during READ for req1 addr=9 -> no rsp1_valid; after release, state is IDLE and the next req0 is served with 2-cycle latency.
- req1_valid dropped before ready while busy -> no grant to requester 1 and no rsp1_valid.
